// File: rtl/mrsc_valid_ready_if.sv
// Handshake bundle between N_REQ requesters, the arbiter/FIFO and one completer.
interface mrsc_valid_ready_if #(
  parameter int DSIZE = 4,
  parameter int N_REQ = 4,
  parameter int DEPTH = 4,
  parameter int IDW   = $clog2(N_REQ)
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*DSIZE-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   cpl_valid;
  logic [DSIZE-1:0]       cpl_data;
  logic [IDW-1:0]         cpl_id;
  logic                   cpl_ready;
  logic [CW-1:0]          fill_level;

  // Producer/consumer side: presents requests and the completer ready.
  modport master (
    output req_valid, req_data, cpl_ready,
    input  req_ready, cpl_valid, cpl_data, cpl_id, fill_level
  );

  // Interconnect side: arbitrates requests and serves the completer.
  modport slave (
    input  req_valid, req_data, cpl_ready,
    output req_ready, cpl_valid, cpl_data, cpl_id, fill_level
  );
endinterface

// File: rtl/mrsc_valid_ready.sv
// Multi-requester, single-completer valid/ready interconnect: a round-robin
// arbiter picks one requester per cycle and pushes {id, data} into a FIFO
// that the completer drains under its own backpressure.
module mrsc_valid_ready #(
  parameter int DSIZE = 4,
  parameter int N_REQ = 4,
  parameter int DEPTH = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input logic               clk,
  input logic               rst,
  mrsc_valid_ready_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int IW1 = IDW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DSIZE-1:0] mem_data_q [DEPTH];
  logic [IDW-1:0]   mem_id_q   [DEPTH];

  logic             full;
  logic             empty;
  logic             gnt_vld;
  logic             push;
  logic             pop;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;
  logic [IW1-1:0]   cand_sum;
  logic [DSIZE-1:0] push_data;
  logic [N_REQ-1:0] ready_vec;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Scan requesters from rr_ptr_q upward (mod N_REQ); first valid one wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + IW1'(k);
      if (cand_sum >= IW1'(N_REQ)) begin
        cand_sum = cand_sum - IW1'(N_REQ);
      end
      cand = cand_sum[IDW-1:0];
      if (!gnt_vld && bus.req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Ready never looks at cpl_ready: full alone gates it, so there is no
  // combinational path from the completer back to the requesters.
  assign push = gnt_vld && !full && !rst;
  assign pop  = !empty && bus.cpl_ready;

  // One-hot ready for the granted index and mux of its data.
  always_comb begin
    ready_vec = '0;
    push_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        ready_vec[i] = push;
        push_data    = bus.req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  assign bus.req_ready = ready_vec;

  // Next-state for pointers, occupancy and round-robin pointer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      rr_ptr_d = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards all FIFO contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // FIFO storage: data and source tag written at the tail on push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= push_data;
      mem_id_q[wr_ptr_q]   <= gnt_idx;
    end
  end

  // Head entry is masked to zero while the FIFO is empty.
  assign bus.cpl_valid  = !empty;
  assign bus.cpl_data   = empty ? '0 : mem_data_q[rd_ptr_q];
  assign bus.cpl_id     = empty ? '0 : mem_id_q[rd_ptr_q];
  assign bus.fill_level = count_q;

endmodule

// File: tb/tb_mrsc_valid_ready.sv
// Directed bench for mrsc_valid_ready (N_REQ=4, DEPTH=4, DSIZE=4).
module tb_mrsc_valid_ready;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mrsc_valid_ready_if #(.DSIZE(4), .N_REQ(4), .DEPTH(4)) bus ();

  mrsc_valid_ready #(.DSIZE(4), .N_REQ(4), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [15:0] data;
    logic        cr;
    logic [3:0]  exp_ready;
    logic        exp_cv;
    logic [3:0]  exp_cd;
    logic [1:0]  exp_id;
    logic [2:0]  exp_fill;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic r, logic [3:0] vl, logic [15:0] d, logic c,
                             logic [3:0] er, logic ecv, logic [3:0] ecd,
                             logic [1:0] eid, logic [2:0] ef);
    vec_t t;
    t.rst = r; t.valid = vl; t.data = d; t.cr = c;
    t.exp_ready = er; t.exp_cv = ecv; t.exp_cd = ecd; t.exp_id = eid; t.exp_fill = ef;
    return t;
  endfunction

  task automatic chk(input string name, input int row, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h, expected %h", name, row, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs before the edge, then clock.
  task automatic apply(input vec_t t, input string tag, input int row);
    rst           = t.rst;
    bus.req_valid = t.valid;
    bus.req_data  = t.data;
    bus.cpl_ready = t.cr;
    #1;
    chk({tag, ".req_ready"},  row, 16'(bus.req_ready),  16'(t.exp_ready));
    chk({tag, ".cpl_valid"},  row, 16'(bus.cpl_valid),  16'(t.exp_cv));
    chk({tag, ".cpl_data"},   row, 16'(bus.cpl_data),   16'(t.exp_cd));
    chk({tag, ".cpl_id"},     row, 16'(bus.cpl_id),     16'(t.exp_id));
    chk({tag, ".fill_level"}, row, 16'(bus.fill_level), 16'(t.exp_fill));
    @(posedge clk);
    #1;
  endtask

  // Requester protocol: a pending request must hold valid and data.
  logic [3:0]  pv;
  logic [3:0]  pr;
  logic [15:0] pd;
  logic        prst = 1'b1;
  bit          mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en && !prst) begin
      for (int i = 0; i < 4; i++) begin
        if (pv[i] && !pr[i]) begin
          n_checks++;
          if (!bus.req_valid[i] || bus.req_data[i*4 +: 4] !== pd[i*4 +: 4]) begin
            n_fail++;
            $display("FAIL req_hold ch%0d: valid=%b data=%h, expected valid=1 data=%h",
                     i, bus.req_valid[i], bus.req_data[i*4 +: 4], pd[i*4 +: 4]);
          end
        end
      end
    end
    pv   <= bus.req_valid;
    pr   <= bus.req_ready;
    pd   <= bus.req_data;
    prst <= rst;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single transfer, then empty-pop idling, then reset.
    tbl.push_back(v(0, 4'b0100, 16'h0B00, 1, 4'b0100, 0, 4'h0, 0, 0));
    tbl.push_back(v(0, 4'b0000, 16'h0000, 1, 4'b0000, 1, 4'hB, 2, 1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'h0, 0, 0));
    tbl.push_back(v(1, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'h0, 0, 0));
    // Round-robin with all four requesters valid, then each drops after its grant.
    tbl.push_back(v(0, 4'b1111, 16'h4321, 1, 4'b0001, 0, 4'h0, 0, 0));
    tbl.push_back(v(0, 4'b1111, 16'h4321, 1, 4'b0010, 1, 4'h1, 0, 1));
    tbl.push_back(v(0, 4'b1111, 16'h4321, 1, 4'b0100, 1, 4'h2, 1, 1));
    tbl.push_back(v(0, 4'b1111, 16'h4321, 1, 4'b1000, 1, 4'h3, 2, 1));
    tbl.push_back(v(0, 4'b1111, 16'h4321, 1, 4'b0001, 1, 4'h4, 3, 1));
    tbl.push_back(v(0, 4'b1110, 16'h4321, 1, 4'b0010, 1, 4'h1, 0, 1));
    tbl.push_back(v(0, 4'b1100, 16'h4321, 1, 4'b0100, 1, 4'h2, 1, 1));
    tbl.push_back(v(0, 4'b1000, 16'h4321, 1, 4'b1000, 1, 4'h3, 2, 1));
    tbl.push_back(v(0, 4'b0000, 16'h0000, 1, 4'b0000, 1, 4'h4, 3, 1));
    tbl.push_back(v(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'h0, 0, 0));

    // Initial reset with every requester valid: ready must stay low.
    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_data  = 16'h4321;
    bus.cpl_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    chk("reset.req_ready",  0, 16'(bus.req_ready),  16'h0);
    chk("reset.cpl_valid",  0, 16'(bus.cpl_valid),  16'h0);
    chk("reset.cpl_data",   0, 16'(bus.cpl_data),   16'h0);
    chk("reset.cpl_id",     0, 16'(bus.cpl_id),     16'h0);
    chk("reset.fill_level", 0, 16'(bus.fill_level), 16'h0);

    for (int r = 0; r < tbl.size(); r++) apply(tbl[r], "tbl", r);

    // Backpressure: fill to four, one pop cycle grants nothing, push follows.
    apply(v(0, 4'b0011, 16'h005A, 0, 4'b0001, 0, 4'h0, 0, 0), "full", 1);
    apply(v(0, 4'b0011, 16'h005A, 0, 4'b0010, 1, 4'hA, 0, 1), "full", 2);
    apply(v(0, 4'b0011, 16'h005A, 0, 4'b0001, 1, 4'hA, 0, 2), "full", 3);
    apply(v(0, 4'b0011, 16'h005A, 0, 4'b0010, 1, 4'hA, 0, 3), "full", 4);
    apply(v(0, 4'b0011, 16'h005A, 0, 4'b0000, 1, 4'hA, 0, 4), "full", 5);
    apply(v(0, 4'b0011, 16'h005A, 1, 4'b0000, 1, 4'hA, 0, 4), "full", 6);
    apply(v(0, 4'b0011, 16'h005A, 0, 4'b0001, 1, 4'h5, 1, 3), "full", 7);
    apply(v(0, 4'b0011, 16'h005A, 1, 4'b0000, 1, 4'h5, 1, 4), "full", 8);

    // Reset with three entries queued; first grant afterwards is lowest index.
    apply(v(1, 4'b0011, 16'h005A, 0, 4'b0000, 1, 4'hA, 0, 3), "rstmid", 1);
    apply(v(0, 4'b0110, 16'h0C50, 0, 4'b0010, 0, 4'h0, 0, 0), "rstmid", 2);

    // Simultaneous push and pop at fill level 2 keeps occupancy and order.
    apply(v(0, 4'b0100, 16'h0C50, 0, 4'b0100, 1, 4'h5, 1, 1), "pushpop", 1);
    apply(v(0, 4'b1000, 16'h7000, 1, 4'b1000, 1, 4'h5, 1, 2), "pushpop", 2);
    apply(v(0, 4'b0001, 16'h0009, 1, 4'b0001, 1, 4'hC, 2, 2), "pushpop", 3);
    apply(v(0, 4'b0000, 16'h0000, 1, 4'b0000, 1, 4'h7, 3, 2), "pushpop", 4);
    apply(v(0, 4'b0000, 16'h0000, 1, 4'b0000, 1, 4'h9, 0, 1), "pushpop", 5);
    apply(v(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'h0, 0, 0), "pushpop", 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mrsc_valid_ready.md
Name: mrsc_valid_ready

Overview:
- Multi-requester, single-completer valid/ready interconnect.
- N_REQ requester channels, each DSIZE bits wide, feed one completer through a round-robin arbiter and a DEPTH-entry FIFO.
- Adds two behaviours the single-channel block lacks: completer backpressure (cpl_ready) and source tagging (cpl_id).
- Sits between several producers and one shared consumer.

Parameters:
- DSIZE, 4, data width per channel.
- N_REQ, 4, number of requesters (2..16).
- DEPTH, 4, FIFO entries; power of two, >= 2.
- IDW, $clog2(N_REQ), width of the source tag.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester valid.
- req_data  in  N_REQ*DSIZE  packed data; channel i occupies bits [i*DSIZE +: DSIZE].
- req_ready  out  N_REQ  per-requester ready; one-hot or zero.
- cpl_valid  out  1  FIFO head is valid.
- cpl_data  out  DSIZE  head data.
- cpl_id  out  IDW  requester index of the head entry.
- cpl_ready  in  1  completer accepts the head.
- fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset state (rst high at a rising edge):
  - FIFO pointers and count cleared; fill_level=0; cpl_valid=0.
  - cpl_data=0, cpl_id=0.
  - Round-robin pointer points at requester 0.
- While rst is high, req_ready = 0 regardless of other inputs.
- Arbitration (combinational, same cycle):
  - If the FIFO is not full, grant the first valid requester scanning from index rr_ptr upward, wrapping modulo N_REQ.
  - req_ready[g]=1 for the granted index only; all other bits are 0.
  - If the FIFO is full or no requester is valid, req_ready=0.
- req_ready depends only on req_valid, rr_ptr and the full flag. It never depends on cpl_ready, so there is no combinational path from the completer to the requesters.
- Push: when req_valid[g] && req_ready[g] at an edge, write {g, data_g} to the tail; rr_ptr <= (g+1) mod N_REQ.
- rr_ptr is unchanged on any cycle with no transfer.
- Pop: when cpl_valid && cpl_ready at an edge, advance the head.
- Outputs:
  - cpl_valid = (count != 0).
  - cpl_data and cpl_id are the head entry, forced to 0 when empty.
- Latency: data accepted at edge t is at the outputs right after edge t (one cycle) if the FIFO was empty. Otherwise it follows FIFO order.
- Simultaneous push and pop:
  - Count unchanged, both pointers advance.
  - When full, no push is granted that cycle even if a pop occurs (full blocks ready). The push is granted the next cycle.
- Empty with cpl_ready=1: no pop; count stays 0; no underflow.
- Pointers are log2(DEPTH) bits and wrap naturally. count is one bit wider to distinguish full from empty; fill_level = count.
- Requester protocol:
  - Once req_valid[i] is raised, data_i and valid_i must stay stable until the handshake completes.
  - The block does not check this; the bench asserts it.
- Completer protocol: cpl_valid, cpl_data and cpl_id stay stable while cpl_ready=0.
- Reset mid-operation: all FIFO contents are discarded. Requesters must re-present their data after rst deasserts.
- Ordering:
  - Per-requester order is preserved.
  - Cross-requester order equals grant order.

Test Plan:
- Single transfer: N_REQ=4, DEPTH=4, cpl_ready=1. Requester 2 sends 4'hB.
  -> req_ready=4'b0100 in the same cycle. The next cycle has cpl_valid=1, cpl_data=B, cpl_id=2, fill_level=1. The following cycle has fill_level=0.
- Round-robin fairness: all four requesters are held valid with data 4'h1..4'h4, cpl_ready=1.
  -> Grants are 0,1,2,3,0,…; cpl_id sequence 0,1,2,3; no requester starved. Re-grant of 0 occurs only after 3.
- Backpressure and full: cpl_ready=0, requesters 0 and 1 continuously valid (0xA, 0x5).
  -> Four pushes, then fill_level=4 and req_ready=0.
  -> Raising cpl_ready for one cycle pops A. The next push is granted on the following cycle; no push occurs in the pop cycle.
- Simultaneous push/pop at fill_level=2.
  -> fill_level stays 2 and the output order matches grant order.
- Empty pop: cpl_ready=1, no valids for 5 cycles.
  -> cpl_valid=0, cpl_data=0, cpl_id=0, fill_level=0 throughout.
- Reset mid-stream: assert rst for 1 cycle with fill_level=3.
  -> The next cycle has fill_level=0 and cpl_valid=0. req_ready=0 while rst is high. The first grant after reset goes to the lowest valid index.
